jedro_1_prefetch_ifu: RTL
=========================

# jedro_1_prefetch_ifu

Parametrised instruction fetch unit with a prefetch FIFO and multiple outstanding bus requests, sitting between the instruction memory port and the decoder of the jedro_1 core. It keeps up to `MAX_OUTSTANDING` read requests in flight and buffers responses in a `FIFO_DEPTH`-entry queue tagged with PC and bus-error status. On a jump it flushes the queue and silently drops the responses already in flight. Misaligned jump targets raise a sticky exception.

## Interface
- `BOOT_ADDR`, 32'h8000_0000: first fetch address and decoder PC after reset.
- `FIFO_DEPTH`, 4: prefetch entries; power of two, ≥2.
- `MAX_OUTSTANDING`, 2: bus requests in flight (including ones to be discarded); 1..`FIFO_DEPTH`.
- `clk_i`  in  1  single clock; all state on rising edge.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `instr_req_addr_o`  out  DATA_WIDTH  fetch address; always word aligned.
- `instr_req_data_o`  out  DATA_WIDTH  tied 0.
- `instr_req_strobe_o`  out  4  4'b1111 out of reset, 4'b0000 in reset.
- `instr_req_write_o`  out  1  tied 0.
- `instr_req_valid_o`  out  1  request valid.
- `instr_req_ready_i`  in  1  memory accepts request.
- `instr_rsp_data_i`  in  DATA_WIDTH  instruction word.
- `instr_rsp_error_i`  in  1  bus error for this response.
- `instr_rsp_valid_i`  in  1  response valid; responses return in request order.
- `instr_rsp_ready_o`  out  1  tied 1.
- `dec_instr_o`  out  DATA_WIDTH  FIFO head instruction.
- `dec_pc_o`  out  DATA_WIDTH  PC of FIFO head.
- `dec_bus_err_o`  out  1  FIFO head came from an errored response.
- `dec_valid_o`  out  1  FIFO non-empty.
- `dec_ready_i`  in  1  decoder pops head when `dec_valid_o` is high.
- `jmp_addr_valid_i`  in  1  redirect fetch to `jmp_addr_i`.
- `jmp_addr_i`  in  DATA_WIDTH  jump target.
- `exception_ro`  out  1  registered, sticky misaligned-target flag.
- `fault_addr_ro`  out  DATA_WIDTH  registered offending target.

## Operation
- State: `fetch_addr`, `dec_pc`, `fifo_cnt` (0..`FIFO_DEPTH`), `outstanding` (0..`MAX_OUTSTANDING`), `discard_cnt` (≤ `outstanding`), `halted`.
- Issue: `instr_req_valid_o` = !`halted` & !`jmp_addr_valid_i` & `outstanding` < `MAX_OUTSTANDING` & (`fifo_cnt` + `outstanding` − `discard_cnt`) < `FIFO_DEPTH`.
  - This credit rule guarantees the FIFO never overflows.
  - On handshake, `fetch_addr` increments by 4 (32-bit wrap) and `outstanding` increments.
- Response: each `instr_rsp_valid_i` decrements `outstanding`.
  - If `discard_cnt` > 0, the response is dropped and `discard_cnt` decrements.
  - Otherwise {data, error} is pushed to the FIFO.
  - A bus error does not stop fetching.
- Pop: when `dec_valid_o` & `dec_ready_i`, the head is removed and `dec_pc` increments by 4.
- Push and pop in the same cycle leave `fifo_cnt` unchanged. This is legal at full or empty.
- Jump (priority over issue, pop and push in that cycle):
  - FIFO is cleared.
  - `discard_cnt` is set to `outstanding` minus 1 if a response arrives this cycle, else `outstanding`.
  - `fetch_addr` and `dec_pc` are loaded with `jmp_addr_i`.
- Misaligned jump (`jmp_addr_i[1:0]` ≠ 0):
  - Jump handling as above.
  - `exception_ro` is set to 1, `fault_addr_ro` to `jmp_addr_i`, and `halted` to 1.
  - No requests are issued while `halted`.
  - A later aligned jump clears `exception_ro` and `halted`.
- A response with `outstanding` = 0 is a protocol violation; the bench flags it with an assertion.

## Timing
- Reset (asynchronous) clears:
  - `fifo_cnt`, `outstanding`, `discard_cnt`, `halted`.
  - `dec_valid_o` = 0, `dec_bus_err_o` = 0, `dec_instr_o` = 0.
  - `exception_ro` = 0, `fault_addr_ro` = 0.
  - `instr_req_valid_o` = 0, strobe = 0.
  - `instr_req_addr_o` = `dec_pc_o` = `BOOT_ADDR`.
- First cycle after reset release: `instr_req_valid_o` = 1, addr = `BOOT_ADDR`.
- Response in cycle N gives `dec_valid_o` = 1 in cycle N+1 with that word (registered FIFO write, no bypass).
- Single-cycle memory with `MAX_OUTSTANDING` ≥ 2 sustains 1 instruction per cycle. With `MAX_OUTSTANDING` = 1, a request can issue at most every other cycle.
- Jump in cycle N:
  - `instr_req_valid_o` = 0 in cycle N (combinational).
  - Cycle N+1: request at the target, `dec_valid_o` = 0.
  - Earliest new instruction reaches the decoder in cycle N+3 with zero-wait memory and no discards.
- `exception_ro` and `fault_addr_ro` update on the edge after the misaligned jump.
- `instr_req_addr_o` is stable while valid is high without ready, except when a jump withdraws the request.

## Test plan
- Reset, then zero-wait memory returning addr as data: requests 0x8000_0000, 0x8000_0004, … on consecutive cycles; decoder sees matching `dec_pc_o`/`dec_instr_o` at one per cycle from cycle 3.
- Hold `dec_ready_i` = 0 with `FIFO_DEPTH` = 4: exactly 4 entries buffered, then `instr_req_valid_o` drops and no overflow. Releasing ready resumes in order.
- Jump to 0x8000_0100 with 2 requests in flight: both late responses are dropped, and the next decoded PC/instr is 0x8000_0100.
- Jump to 0x8000_0102: `exception_ro` = 1, `fault_addr_ro` = 0x8000_0102, no requests issued. A jump to 0x8000_0200 clears the exception and fetch resumes at 0x8000_0200.
- Response with `instr_rsp_error_i` = 1 at 0x8000_0008: that entry has `dec_bus_err_o` = 1, neighbours have 0, and fetch continues.
- Random ready/valid stalls on memory and decoder, plus random jumps and an asynchronous reset mid-burst: a scoreboard shows in-order PCs with no duplicates, and all outputs return to reset values immediately.

Source files
------------

// File: rtl/jedro_1_prefetch_ifu_if.sv
// Instruction memory bus between the jedro_1 prefetch fetch unit (master) and instruction memory (slave).
interface jedro_1_prefetch_ifu_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] instr_req_addr;
   logic [DATA_WIDTH-1:0] instr_req_data;
   logic [3:0]            instr_req_strobe;
   logic                  instr_req_write;
   logic                  instr_req_valid;
   logic                  instr_req_ready;
   logic [DATA_WIDTH-1:0] instr_rsp_data;
   logic                  instr_rsp_error;
   logic                  instr_rsp_valid;
   logic                  instr_rsp_ready;

   modport master (
      output instr_req_addr, instr_req_data, instr_req_strobe, instr_req_write,
             instr_req_valid, instr_rsp_ready,
      input  instr_req_ready, instr_rsp_data, instr_rsp_error, instr_rsp_valid
   );

   modport slave (
      input  instr_req_addr, instr_req_data, instr_req_strobe, instr_req_write,
             instr_req_valid, instr_rsp_ready,
      output instr_req_ready, instr_rsp_data, instr_rsp_error, instr_rsp_valid
   );
endinterface

// File: rtl/jedro_1_prefetch_ifu.sv
// Prefetching instruction fetch unit: keeps several reads in flight, buffers words in a
// tagged FIFO for the decoder, and drops in-flight responses after a jump.
module jedro_1_prefetch_ifu #(
   parameter int                    DATA_WIDTH      = 32,
   parameter logic [DATA_WIDTH-1:0] BOOT_ADDR       = 32'h8000_0000,
   parameter int                    FIFO_DEPTH      = 4,
   parameter int                    MAX_OUTSTANDING = 2
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   jedro_1_prefetch_ifu_if.master instr_bus,
   output logic [DATA_WIDTH-1:0] dec_instr_o,
   output logic [DATA_WIDTH-1:0] dec_pc_o,
   output logic                  dec_bus_err_o,
   output logic                  dec_valid_o,
   input  logic                  dec_ready_i,
   input  logic                  jmp_addr_valid_i,
   input  logic [DATA_WIDTH-1:0] jmp_addr_i,
   output logic                  exception_ro,
   output logic [DATA_WIDTH-1:0] fault_addr_ro
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int SUM_W = CNT_W + 1;

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t             MAX_L   = CNT_W'(MAX_OUTSTANDING);
   localparam logic [SUM_W-1:0] DEPTH_L = SUM_W'(FIFO_DEPTH);

   logic [DATA_WIDTH-3:0] fetch_word;
   logic [DATA_WIDTH-1:0] dec_pc;
   cnt_t                  fifo_cnt;
   cnt_t                  outstanding;
   cnt_t                  discard_cnt;
   logic                  halted;
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;

   logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
   logic                  fifo_err  [FIFO_DEPTH];

   logic [SUM_W-1:0] credits_used;
   logic             req_valid;
   logic             req_fire;
   logic             rsp;
   logic             push;
   logic             pop;
   logic             misaligned;

   // Entries already buffered plus responses still wanted must leave room in the FIFO.
   assign credits_used = SUM_W'(fifo_cnt) + SUM_W'(outstanding) - SUM_W'(discard_cnt);
   assign req_valid    = rstn_i & ~halted & ~jmp_addr_valid_i & (outstanding < MAX_L)
                         & (credits_used < DEPTH_L);
   assign req_fire     = req_valid & instr_bus.instr_req_ready;
   assign rsp          = instr_bus.instr_rsp_valid;
   assign push         = rsp & (discard_cnt == '0) & ~jmp_addr_valid_i;
   assign pop          = dec_valid_o & dec_ready_i & ~jmp_addr_valid_i;
   assign misaligned   = jmp_addr_i[1:0] != 2'b00;

   assign instr_bus.instr_req_addr   = {fetch_word, 2'b00};
   assign instr_bus.instr_req_data   = '0;
   assign instr_bus.instr_req_strobe = {4{rstn_i}};
   assign instr_bus.instr_req_write  = 1'b0;
   assign instr_bus.instr_req_valid  = req_valid;
   assign instr_bus.instr_rsp_ready  = 1'b1;

   assign dec_valid_o   = fifo_cnt != '0;
   assign dec_instr_o   = dec_valid_o ? fifo_data[rd_ptr] : '0;
   assign dec_bus_err_o = dec_valid_o & fifo_err[rd_ptr];
   assign dec_pc_o      = dec_pc;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         fetch_word    <= BOOT_ADDR[DATA_WIDTH-1:2];
         dec_pc        <= BOOT_ADDR;
         fifo_cnt      <= '0;
         outstanding   <= '0;
         discard_cnt   <= '0;
         halted        <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         exception_ro  <= 1'b0;
         fault_addr_ro <= '0;
      end else if (jmp_addr_valid_i) begin
         // Everything still in flight belongs to the old path and must be dropped.
         fifo_cnt     <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         outstanding  <= outstanding - cnt_t'(rsp);
         discard_cnt  <= outstanding - cnt_t'(rsp);
         fetch_word   <= jmp_addr_i[DATA_WIDTH-1:2];
         dec_pc       <= jmp_addr_i;
         halted       <= misaligned;
         exception_ro <= misaligned;
         if (misaligned) begin
            fault_addr_ro <= jmp_addr_i;
         end
      end else begin
         outstanding <= outstanding + cnt_t'(req_fire) - cnt_t'(rsp);
         fifo_cnt    <= fifo_cnt + cnt_t'(push) - cnt_t'(pop);
         if (rsp && discard_cnt != '0) begin
            discard_cnt <= discard_cnt - cnt_t'(1);
         end
         if (req_fire) begin
            fetch_word <= fetch_word + (DATA_WIDTH-2)'(1);
         end
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            dec_pc <= dec_pc + DATA_WIDTH'(4);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_data[wr_ptr] <= instr_bus.instr_rsp_data;
         fifo_err[wr_ptr]  <= instr_bus.instr_rsp_error;
      end
   end
endmodule
